// File: rtl/tpu_batch_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : tpu_batch_ctrl_if
// Description : Bundle of the host command/operand/result streams, the operand
//               SRAM write port, the result SRAM read port and the TPU
//               start/done handshake that tpu_batch_ctrl drives or consumes.
//               master : the batch controller side.
//               slave  : the surrounding host / SRAM / TPU side.
// Ports       : cmd_*  batch command (valid/ready + length)
//               in_*   operand beat stream (valid/ready + A/B data)
//               sram_* operand SRAM write port (active-low strobe)
//               tpu_*  start pulse / completion
//               res_*  result SRAM read port (1-cycle read latency)
//               out_*  result stream to the host (valid/ready + last)
//               busy, err_timeout status
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tpu_batch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 64,
  parameter int RES_W  = 128,
  parameter int RES_AW = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W:0]   cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              sram_we_n;
  logic [ADDR_W-1:0] sram_waddr;
  logic [OP_W-1:0]   sram_wdata_a;
  logic [OP_W-1:0]   sram_wdata_b;
  logic              tpu_start;
  logic              tpu_done;
  logic [RES_AW-1:0] res_raddr;
  logic [RES_W-1:0]  res_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  cmd_valid, cmd_len, in_valid, in_a, in_b, tpu_done, res_rdata, out_ready,
    output cmd_ready, in_ready, sram_we_n, sram_waddr, sram_wdata_a, sram_wdata_b,
           tpu_start, res_raddr, out_valid, out_data, out_last, busy, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_len, in_valid, in_a, in_b, tpu_done, res_rdata, out_ready,
    input  cmd_ready, in_ready, sram_we_n, sram_waddr, sram_wdata_a, sram_wdata_b,
           tpu_start, res_raddr, out_valid, out_data, out_last, busy, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/tpu_batch_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tpu_batch_ctrl
// Description : Host-side batch sequencer for the systolic-array TPU. Accepts a
//               batch command, streams operand beats into the A/B operand
//               SRAMs, pulses tpu_start, waits for tpu_done under a timeout
//               guard, then drains RES_DEPTH result words to the host.
// Ports       : clk    - single clock
//               srstn  - synchronous reset, active low
//               bus    - tpu_batch_ctrl_if.master (command, operand, SRAM,
//                        TPU handshake, result stream and status signals)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_batch_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int OP_W        = 64,
  parameter int RES_W       = 128,
  parameter int RES_DEPTH   = 16,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              srstn,
  tpu_batch_ctrl_if.master  bus
);

  localparam int RES_AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int RUN_W  = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  localparam logic [ADDR_W:0]   BEAT_ONE = (ADDR_W+1)'(1);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [RES_AW-1:0] RES_ONE  = RES_AW'(1);
  localparam logic [RES_AW-1:0] RES_LAST = RES_AW'(RES_DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;

  logic [2:0]        state;
  // One bit wider than the SRAM address so a full 2^ADDR_W batch ends
  // with beat_cnt == len instead of wrapping back to zero.
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   beat_cnt;
  logic [ADDR_W:0]   beat_cnt_inc;
  logic [RUN_W-1:0]  run_cnt;
  logic [RES_AW-1:0] raddr;
  logic              we_n;
  logic [ADDR_W-1:0] waddr;
  logic [OP_W-1:0]   wdata_a;
  logic [OP_W-1:0]   wdata_b;
  logic [RES_W-1:0]  out_data_q;
  logic              out_last_q;
  logic              err;

  assign beat_cnt_inc = beat_cnt + BEAT_ONE;

  // Handshake outputs are pure state decodes: no ready->valid combinational path.
  assign bus.cmd_ready    = (state == S_IDLE);
  assign bus.in_ready     = (state == S_LOAD);
  assign bus.tpu_start    = (state == S_START);
  assign bus.out_valid    = (state == S_OUT);
  assign bus.busy         = (state != S_IDLE);
  assign bus.sram_we_n    = we_n;
  assign bus.sram_waddr   = waddr;
  assign bus.sram_wdata_a = wdata_a;
  assign bus.sram_wdata_b = wdata_b;
  assign bus.res_raddr    = raddr;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.err_timeout  = err;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state      <= S_IDLE;
      len        <= '0;
      beat_cnt   <= '0;
      run_cnt    <= '0;
      raddr      <= '0;
      we_n       <= 1'b1;
      waddr      <= '0;
      wdata_a    <= '0;
      wdata_b    <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted beat.
      we_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            len      <= bus.cmd_len;
            beat_cnt <= '0;
            err      <= 1'b0;
            state    <= (bus.cmd_len == '0) ? S_START : S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            we_n     <= 1'b0;
            waddr    <= beat_cnt[ADDR_W-1:0];
            wdata_a  <= bus.in_a;
            wdata_b  <= bus.in_b;
            beat_cnt <= beat_cnt_inc;
            if (beat_cnt_inc == len) begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          run_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          // Completion takes priority over a coincident timeout.
          if (bus.tpu_done) begin
            state <= S_RD;
          end else if (run_cnt == RUN_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            run_cnt <= run_cnt + RUN_ONE;
          end
        end
        S_RD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Read data for the address driven in RD is valid this cycle.
          out_data_q <= bus.res_rdata;
          out_last_q <= (raddr == RES_LAST);
          state      <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_last_q <= 1'b0;
            if (raddr == RES_LAST) begin
              raddr <= '0;
              state <= S_IDLE;
            end else begin
              raddr <= raddr + RES_ONE;
              state <= S_RD;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
